logic_gate_unit: RTL



---
 rtl/logic_gate_unit_if.sv | 37 +++
 rtl/logic_gate_unit.sv | 78 +++++++
 2 files changed

// File: rtl/logic_gate_unit_if.sv
// logic_gate_unit_if: beat-in/result-out stream bundle; out_zero/out_parity exist only with LOGIC_GATE_UNIT_FLAGS_EN
interface logic_gate_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic [CNT_W-1:0] out_beats;
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
   logic             out_zero;
   logic             out_parity;
   modport master (
      output in_valid, a, b, op, in_last, out_ready,
      input  in_ready, out_valid, Y, out_beats, out_zero, out_parity
   );
   modport slave (
      input  in_valid, a, b, op, in_last, out_ready,
      output in_ready, out_valid, Y, out_beats, out_zero, out_parity
   );
`else
   modport master (
      output in_valid, a, b, op, in_last, out_ready,
      input  in_ready, out_valid, Y, out_beats
   );
   modport slave (
      input  in_valid, a, b, op, in_last, out_ready,
      output in_ready, out_valid, Y, out_beats
   );
`endif
endinterface

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered op-selectable bitwise gate with multi-beat packet reduction; LOGIC_GATE_UNIT_FLAGS_EN adds out_zero/out_parity
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic rst_n,
   logic_gate_unit_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACC  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [0:0]       state;
   logic [2:0]       pkt_op, eff_op;
   logic [1:0]       fn;
   logic             inv, take;
   logic [WIDTH-1:0] acc, r, acc_n, res, y_q;
   logic [CNT_W-1:0] cnt, cnt_n, beats_q;
   logic             valid_q;
   // fn: 0 AND, 1 OR, 2 XOR, 3 pass a; the open packet keeps the op of its first beat
   always_comb begin
      eff_op = (state == ACC) ? pkt_op : bus.op;
      fn     = (eff_op == 3'd0 || eff_op == 3'd3) ? 2'd0 :
               (eff_op == 3'd1 || eff_op == 3'd4) ? 2'd1 :
               (eff_op == 3'd2 || eff_op == 3'd5) ? 2'd2 : 2'd3;
      inv    = eff_op inside {3'd3, 3'd4, 3'd5, 3'd6};
      r      = (fn == 2'd0) ? (bus.a & bus.b) :
               (fn == 2'd1) ? (bus.a | bus.b) :
               (fn == 2'd2) ? (bus.a ^ bus.b) : bus.a;
      acc_n  = (state == IDLE || fn == 2'd3) ? r :
               (fn == 2'd0) ? (acc & r) :
               (fn == 2'd1) ? (acc | r) : (acc ^ r);
      res    = inv ? ~acc_n : acc_n;
      cnt_n  = (state == IDLE) ? CNT_W'(1) : (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   end
   assign bus.in_ready  = rst_n & (!valid_q | bus.out_ready);
   assign take          = bus.in_valid & bus.in_ready;
   assign bus.out_valid = valid_q;
   assign bus.Y         = y_q;
   assign bus.out_beats = beats_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pkt_op  <= 3'd0;
         acc     <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
         y_q     <= '0;
         beats_q <= '0;
      end else begin
         valid_q <= (take & bus.in_last) | (valid_q & !bus.out_ready);
         if (take) begin
            acc    <= acc_n;
            cnt    <= cnt_n;
            pkt_op <= eff_op;
            state  <= bus.in_last ? IDLE : ACC;
            if (bus.in_last) begin
               y_q     <= res;
               beats_q <= cnt_n;
            end
         end
      end
   end
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
   logic zero_q, parity_q;
   assign bus.out_zero   = zero_q;
   assign bus.out_parity = parity_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
      end else if (take && bus.in_last) begin
         zero_q   <= (res == '0);
         parity_q <= ^res;
      end
   end
`endif
endmodule
